// File: rtl/clint.sv
// Core-local interruptor: machine/supervisor software-interrupt bits, the free-running
// 64-bit mtime with its prescaler, mtimecmp, and a single-cycle request/ack bus slave.
module clint #(
`ifdef RV64I
  parameter int DATA_SIZE    = 64,
`else
  parameter int DATA_SIZE    = 32,
`endif
  parameter int CLOCK_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE/8-1:0] byte_en,
  input  logic [15:0]            addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   ack,
  output logic                   mem_msip,
  output logic                   mem_ssip,
  output logic [63:0]            mem_mtime,
  output logic [63:0]            mem_mtimecmp
);

  localparam int NB = DATA_SIZE / 8;
  localparam int PW = (CLOCK_CYCLES > 1) ? $clog2(CLOCK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_CYCLES - 1);
  localparam logic [15:0]   LANE_MASK  = 16'(NB - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                             input logic [63:0] new_v,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
  logic                   msip_q, msip_d;
  logic                   ssip_q, ssip_d;
  logic [63:0]            mtime_q, mtime_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic [PW-1:0]          presc_q, presc_d;

  logic                   access_s;
  logic                   do_wr_s;
  logic                   do_rd_s;
  logic                   tick_s;
  logic [15:0]            aligned_s;
  logic                   hit_msip_s, hit_ssip_s, hit_cmp_s, hit_time_s;
  logic [7:0]             wmask_s;
  logic [63:0]            wdata_s;
  logic [63:0]            rd64_s;
  logic [DATA_SIZE-1:0]   rword_s;

  // Offsets ignore the byte-within-word bits; 32-bit buses split 64-bit registers in two words.
  assign aligned_s  = addr & ~LANE_MASK;
  assign hit_msip_s = (aligned_s == 16'h0000);
  assign hit_ssip_s = (aligned_s == 16'hC000);
  assign hit_cmp_s  = (aligned_s[15:3] == 13'h0800);
  assign hit_time_s = (aligned_s[15:3] == 13'h17FF);

  generate
    if (DATA_SIZE == 64) begin : g_dw64
      assign wmask_s = byte_en;
      assign wdata_s = wr_data;
      assign rword_s = rd64_s;
    end else begin : g_dw32
      logic hi_s;
      assign hi_s    = aligned_s[2];
      assign wmask_s = hi_s ? {byte_en, 4'b0000} : {4'b0000, byte_en};
      assign wdata_s = hi_s ? {wr_data, 32'h0000_0000} : {32'h0000_0000, wr_data};
      assign rword_s = hi_s ? rd64_s[63:32] : rd64_s[31:0];
    end
  endgenerate

  // Full 64-bit view of the addressed register; unmapped offsets read zero.
  always_comb begin
    rd64_s = 64'h0;
    if (hit_cmp_s) begin
      rd64_s = mtimecmp_q;
    end else if (hit_time_s) begin
      rd64_s = mtime_q;
    end else if (hit_msip_s) begin
      rd64_s = {63'h0, msip_q};
    end else if (hit_ssip_s) begin
      rd64_s = {63'h0, ssip_q};
    end else begin
      rd64_s = 64'h0;
    end
  end

  // Bus FSM: accept a request in IDLE, pulse ack in ACK, requests in ACK are dropped.
  always_comb begin
    state_d  = state_q;
    access_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_en || wr_en) begin
          access_s = 1'b1;
          state_d  = ST_ACK;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign do_wr_s = access_s && wr_en;
  assign do_rd_s = access_s && !wr_en;
  assign tick_s  = (presc_q == PRESC_LAST);

  // Register updates; a write to either mtime word replaces that cycle's increment.
  always_comb begin
    ack_d      = access_s;
    rd_data_d  = rd_data_q;
    msip_d     = msip_q;
    ssip_d     = ssip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    presc_d    = presc_q;

    if (tick_s) begin
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = presc_q + PW'(1);
    end

    if (do_wr_s && hit_time_s) begin
      mtime_d = byte_merge(mtime_q, wdata_s, wmask_s);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'd1;
    end else begin
      mtime_d = mtime_q;
    end

    if (do_wr_s && hit_cmp_s) begin
      mtimecmp_d = byte_merge(mtimecmp_q, wdata_s, wmask_s);
    end else begin
      mtimecmp_d = mtimecmp_q;
    end

    if (do_wr_s && hit_msip_s && byte_en[0]) begin
      msip_d = wr_data[0];
    end else begin
      msip_d = msip_q;
    end

    if (do_wr_s && hit_ssip_s && byte_en[0]) begin
      ssip_d = wr_data[0];
    end else begin
      ssip_d = ssip_q;
    end

    if (do_rd_s) begin
      rd_data_d = rword_s;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      rd_data_q  <= {DATA_SIZE{1'b0}};
      msip_q     <= 1'b0;
      ssip_q     <= 1'b0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q    <= {PW{1'b0}};
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      msip_q     <= msip_d;
      ssip_q     <= ssip_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      presc_q    <= presc_d;
    end
  end

  assign ack          = ack_q;
  assign rd_data      = rd_data_q;
  assign mem_msip     = msip_q;
  assign mem_ssip     = ssip_q;
  assign mem_mtime    = mtime_q;
  assign mem_mtimecmp = mtimecmp_q;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: reference model of the register map and timer, a directed vector
// table, hand-written corner sequences and a randomized bus phase.
module tb_clint;

  localparam int CC1 = 1;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic        wr_en;
  logic [3:0]  byte_en;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic        mem_msip;
  logic        mem_ssip;
  logic [63:0] mem_mtime;
  logic [63:0] mem_mtimecmp;

  logic [31:0] rd_data4;
  logic        ack4;
  logic        msip4;
  logic        ssip4;
  logic [63:0] mtime4;
  logic [63:0] mtimecmp4;

  clint #(.DATA_SIZE(32), .CLOCK_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .byte_en(byte_en),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .ack(ack),
    .mem_msip(mem_msip), .mem_ssip(mem_ssip), .mem_mtime(mem_mtime),
    .mem_mtimecmp(mem_mtimecmp)
  );

  clint #(.DATA_SIZE(32), .CLOCK_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .rd_en(1'b0), .wr_en(1'b0), .byte_en(4'h0),
    .addr(16'h0000), .wr_data(32'h0), .rd_data(rd_data4), .ack(ack4),
    .mem_msip(msip4), .mem_ssip(ssip4), .mem_mtime(mtime4), .mem_mtimecmp(mtimecmp4)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic        m_ack;
  logic [31:0] m_rd;
  logic        m_msip;
  logic        m_ssip;
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  int          m_edges;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ack   = 1'b0;
    m_rd    = 32'h0;
    m_msip  = 1'b0;
    m_ssip  = 1'b0;
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_edges = 0;
  endtask

  task automatic model_step();
    logic        acc;
    logic        tick;
    logic [15:0] off;
    logic [63:0] nt;
    tick = ((m_edges % CC1) == (CC1 - 1));
    nt   = tick ? m_mtime + 64'd1 : m_mtime;
    acc  = !m_ack && (rd_en || wr_en);
    off  = addr & 16'hFFFC;
    if (acc && wr_en) begin
      case (off)
        16'h0000: if (byte_en[0]) m_msip = wr_data[0];
        16'hC000: if (byte_en[0]) m_ssip = wr_data[0];
        16'h4000: m_cmp[31:0]  = lanes(m_cmp[31:0], wr_data, byte_en);
        16'h4004: m_cmp[63:32] = lanes(m_cmp[63:32], wr_data, byte_en);
        16'hBFF8: nt = {m_mtime[63:32], lanes(m_mtime[31:0], wr_data, byte_en)};
        16'hBFFC: nt = {lanes(m_mtime[63:32], wr_data, byte_en), m_mtime[31:0]};
        default: ;
      endcase
    end else if (acc) begin
      case (off)
        16'h0000: m_rd = {31'h0, m_msip};
        16'hC000: m_rd = {31'h0, m_ssip};
        16'h4000: m_rd = m_cmp[31:0];
        16'h4004: m_rd = m_cmp[63:32];
        16'hBFF8: m_rd = m_mtime[31:0];
        16'hBFFC: m_rd = m_mtime[63:32];
        default:  m_rd = 32'h0;
      endcase
    end
    m_mtime = nt;
    m_ack   = acc;
    m_edges++;
  endtask

  task automatic check_all();
    chk("ack", 64'(ack), 64'(m_ack));
    chk("rd_data", 64'(rd_data), 64'(m_rd));
    chk("msip", 64'(mem_msip), 64'(m_msip));
    chk("ssip", 64'(mem_ssip), 64'(m_ssip));
    chk("mtime", mem_mtime, m_mtime);
    chk("mtimecmp", mem_mtimecmp, m_cmp);
    chk("mtime_div4", mtime4, 64'(m_edges / 4));
    chk("idle4", {mtimecmp4[31:0], rd_data4, 29'h0, ack4, msip4, ssip4},
        {32'hFFFF_FFFF, 32'h0, 32'h0});
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    model_reset();
    #2;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic bus(input logic w, input logic [15:0] a, input logic [3:0] be,
                     input logic [31:0] d);
    wr_en   = w;
    rd_en   = !w;
    addr    = a;
    byte_en = be;
    wr_data = d;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    byte_en = 4'h0;
    addr    = 16'h0;
    wr_data = 32'h0;
    model_reset();

    tbl[0] = '{16'h0000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[1] = '{16'hC000, 4'hE, 32'h0000_0001, 32'h0000_0000};
    tbl[2] = '{16'hC000, 4'h1, 32'h0000_0003, 32'h0000_0001};
    tbl[3] = '{16'h4004, 4'hF, 32'h1234_5678, 32'h1234_5678};
    tbl[4] = '{16'h4000, 4'h3, 32'hCAFE_BABE, 32'hFFFF_BABE};
    tbl[5] = '{16'h1234, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[6] = '{16'h0004, 4'hF, 32'h0000_0001, 32'h0000_0000};
    tbl[7] = '{16'h0002, 4'hF, 32'h0000_0000, 32'h0000_0000};
    tbl[8] = '{16'h4007, 4'hC, 32'h9ABC_DEF0, 32'h9ABC_5678};
    tbl[9] = '{16'hC003, 4'hF, 32'h0000_0000, 32'h0000_0000};

    // reset values and prescaled timer
    apply_reset();
    chk("rst_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_mtime", mem_mtime, 64'h0);
    chk("rst_sip", {62'h0, mem_msip, mem_ssip}, 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    for (int i = 0; i < 4; i++) step();
    chk("mtime4_after4", mtime4, 64'd1);
    for (int i = 0; i < 4; i++) step();
    chk("mtime4_after8", mtime4, 64'd2);

    // handshake timing
    addr = 16'h0000; byte_en = 4'hF; wr_data = 32'h1; wr_en = 1'b1; rd_en = 1'b0;
    chk("hs_ack_N", 64'(ack), 64'h0);
    step();
    chk("hs_ack_N1", 64'(ack), 64'h1);
    chk("hs_msip_N1", 64'(mem_msip), 64'h1);
    wr_en = 1'b0;
    step();
    chk("hs_ack_N2", 64'(ack), 64'h0);
    addr = 16'h0000; rd_en = 1'b1;
    step();
    chk("hs_rd_ack", 64'(ack), 64'h1);
    chk("hs_rd_data", 64'(rd_data), 64'h1);
    rd_en = 1'b0;
    step();
    bus(1'b1, 16'hC000, 4'hF, 32'h1);
    chk("hs_ssip_set", 64'(mem_ssip), 64'h1);
    bus(1'b1, 16'hC000, 4'hF, 32'h0);
    chk("hs_ssip_clr", 64'(mem_ssip), 64'h0);

    // byte enables on mtimecmp low word
    apply_reset();
    bus(1'b1, 16'h4000, 4'b0101, 32'hAABB_CCDD);
    chk("be_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFBB_FFDD);

    // tick and write colliding
    apply_reset();
    addr = 16'hBFF8; byte_en = 4'hF; wr_data = 32'h10; wr_en = 1'b1;
    step();
    chk("coll_ack_cycle", mem_mtime, 64'h10);
    wr_en = 1'b0;
    step();
    chk("coll_next", mem_mtime, 64'h11);

    // wrap-around of the 64-bit timer
    bus(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF);
    addr = 16'hBFF8; byte_en = 4'hF; wr_data = 32'hFFFF_FFFF; wr_en = 1'b1;
    step();
    chk("wrap_all_ones", mem_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_en = 1'b0;
    step();
    chk("wrap_zero", mem_mtime, 64'h0);

    // reset asserted while ack is high
    bus(1'b1, 16'h4004, 4'hF, 32'h5);
    addr = 16'h0000; byte_en = 4'hF; wr_data = 32'h1; wr_en = 1'b1;
    step();
    chk("rma_ack_before", 64'(ack), 64'h1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rma_ack_drop", 64'(ack), 64'h0);
    chk("rma_msip", 64'(mem_msip), 64'h0);
    chk("rma_mtime", mem_mtime, 64'h0);
    chk("rma_mtimecmp", mem_mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    wr_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    step();
    chk("rma_no_late_ack", 64'(ack), 64'h0);

    // unmapped read after a nonzero read
    bus(1'b0, 16'h4000, 4'hF, 32'h0);
    chk("um_prev_rd", 64'(rd_data), 64'hFFFF_FFFF);
    addr = 16'h1234; rd_en = 1'b1;
    step();
    chk("um_ack", 64'(ack), 64'h1);
    chk("um_rd_data", 64'(rd_data), 64'h0);
    rd_en = 1'b0;
    step();

    // directed vector table: write then read back
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      bus(1'b1, tbl[i].a, tbl[i].be, tbl[i].d);
      bus(1'b0, tbl[i].a, 4'h0, 32'h0);
      chk($sformatf("tbl%0d", i), 64'(rd_data), 64'(tbl[i].exp));
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [15:0] bases [8];
      bases[0] = 16'h0000; bases[1] = 16'h4000; bases[2] = 16'h4004; bases[3] = 16'hBFF8;
      bases[4] = 16'hBFFC; bases[5] = 16'hC000; bases[6] = 16'h1234; bases[7] = 16'h0008;
      wr_en   = ($urandom_range(0, 2) == 0);
      rd_en   = ($urandom_range(0, 2) == 0);
      addr    = bases[$urandom_range(0, 7)] | 16'($urandom_range(0, 3));
      byte_en = 4'($urandom);
      wr_data = $urandom;
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
